// File: rtl/dot_accum_if.sv
// dot_accum_if: beat inputs and row result outputs of the dot_accum lane.
// master drives beats; slave is the compute lane.
interface dot_accum_if #(
    parameter int LANES  = 8,
    parameter int IWIDTH = 8,
    parameter int OWIDTH = 32
);
    logic                       ivalid;
    logic [LANES*IWIDTH-1:0]    vec_data;
    logic [LANES*IWIDTH-1:0]    mat_data;
    logic                       accum_first;
    logic                       accum_last;
    logic signed [OWIDTH-1:0]   result;
    logic                       ovalid;

    modport master (
        output ivalid, vec_data, mat_data,
        output accum_first, accum_last,
        input  result, ovalid
    );

    modport slave (
        input  ivalid, vec_data, mat_data,
        input  accum_first, accum_last,
        output result, ovalid
    );
endinterface

// File: rtl/dot_accum.sv
// dot_accum: pipelined signed word dot product accumulated across a row.
// Define DOT_ACCUM_SAT_EN to saturate accumulation instead of wrapping.
module dot_accum #(
    parameter int LANES  = 8,
    parameter int IWIDTH = 8,
    parameter int OWIDTH = 32
) (
    input logic        clk,
    input logic        rst,
    dot_accum_if.slave io_bus
);
    localparam int LOG2 = $clog2(LANES);
    localparam int TW   = 2*IWIDTH + LOG2;

    logic                    r_s0_v;
    logic                    r_s0_f;
    logic                    r_s0_l;
    logic [LANES*IWIDTH-1:0] r_s0_vec;
    logic [LANES*IWIDTH-1:0] r_s0_mat;

    always_ff @(posedge clk) begin
        if (rst) r_s0_v <= 1'b0;
        else     r_s0_v <= io_bus.ivalid;
        r_s0_f   <= io_bus.accum_first;
        r_s0_l   <= io_bus.accum_last;
        r_s0_vec <= io_bus.vec_data;
        r_s0_mat <= io_bus.mat_data;
    end

    // Level 0 holds the products; each later level halves the count
    // and grows one bit.
    for (genvar l = 0; l <= LOG2; l++) begin : g_lvl
        localparam int W = 2*IWIDTH + l;
        localparam int N = LANES >> l;

        logic signed [W-1:0] r_sum [N];
        logic                r_v;
        logic                r_f;
        logic                r_l;

        if (l == 0) begin : g_mul
            always_ff @(posedge clk) begin
                if (rst) r_v <= 1'b0;
                else     r_v <= r_s0_v;
                r_f <= r_s0_f;
                r_l <= r_s0_l;
                for (int k = 0; k < N; k++) begin
                    r_sum[k] <=
                        W'($signed(r_s0_vec[k*IWIDTH +: IWIDTH])) *
                        W'($signed(r_s0_mat[k*IWIDTH +: IWIDTH]));
                end
            end
        end else begin : g_add
            always_ff @(posedge clk) begin
                if (rst) r_v <= 1'b0;
                else     r_v <= g_lvl[l-1].r_v;
                r_f <= g_lvl[l-1].r_f;
                r_l <= g_lvl[l-1].r_l;
                for (int k = 0; k < N; k++) begin
                    r_sum[k] <=
                        W'(g_lvl[l-1].r_sum[2*k]) +
                        W'(g_lvl[l-1].r_sum[2*k+1]);
                end
            end
        end
    end

    logic                     w_top_v;
    logic                     w_top_f;
    logic                     w_top_l;
    logic signed [TW-1:0]     w_top_s;
    logic signed [OWIDTH-1:0] w_sext;
    logic signed [OWIDTH-1:0] w_acc_nxt;
    logic signed [OWIDTH-1:0] r_acc;
    logic                     r_fin;
    logic signed [OWIDTH-1:0] r_result;
    logic                     r_ovalid;

    assign w_top_v = g_lvl[LOG2].r_v;
    assign w_top_f = g_lvl[LOG2].r_f;
    assign w_top_l = g_lvl[LOG2].r_l;
    assign w_top_s = g_lvl[LOG2].r_sum[0];
    assign w_sext  = OWIDTH'(w_top_s);

`ifdef DOT_ACCUM_SAT_EN
    logic signed [OWIDTH:0] w_wide;
    assign w_wide = (OWIDTH+1)'(r_acc) + (OWIDTH+1)'(w_sext);

    // Overflow shows as the top two bits of the wide sum disagreeing.
    always_comb begin
        w_acc_nxt = w_wide[OWIDTH-1:0];
        if (w_top_f) begin
            w_acc_nxt = w_sext;
        end else if (w_wide[OWIDTH] != w_wide[OWIDTH-1]) begin
            w_acc_nxt = w_wide[OWIDTH]
                ? {1'b1, {(OWIDTH-1){1'b0}}}
                : {1'b0, {(OWIDTH-1){1'b1}}};
        end
    end
`else
    always_comb begin
        w_acc_nxt = r_acc + w_sext;
        if (w_top_f) w_acc_nxt = w_sext;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
            r_fin <= 1'b0;
        end else begin
            r_fin <= w_top_v & w_top_l;
            if (w_top_v) r_acc <= w_acc_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_result <= '0;
            r_ovalid <= 1'b0;
        end else begin
            r_ovalid <= r_fin;
            if (r_fin) r_result <= r_acc;
        end
    end

    assign io_bus.result = r_result;
    assign io_bus.ovalid = r_ovalid;
endmodule

// File: tb/tb_dot_accum.sv
// tb_dot_accum: directed and random rows checked against a row-level model.
// Honours DOT_ACCUM_SAT_EN for the expected accumulation rule.
module tb_dot_accum;
    localparam int LANES  = 8;
    localparam int IWIDTH = 8;
    localparam int OWIDTH = 32;
    localparam int LAT    = 6;
    localparam int WW     = LANES*IWIDTH;

    typedef struct {
        int                       due;
        logic signed [OWIDTH-1:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    dot_accum_if #(
        .LANES(LANES), .IWIDTH(IWIDTH), .OWIDTH(OWIDTH)
    ) bus ();

    dot_accum #(
        .LANES(LANES), .IWIDTH(IWIDTH), .OWIDTH(OWIDTH)
    ) u_dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    always #5 clk = ~clk;

    int                       checks   = 0;
    int                       failures = 0;
    int                       cyc      = 0;
    exp_t                     q[$];
    longint                   acc_m    = 0;
    logic signed [OWIDTH-1:0] last_res = '0;

    function automatic logic [WW-1:0] rep(input logic [IWIDTH-1:0] e);
        return {LANES{e}};
    endfunction

    function automatic longint dot(input logic [WW-1:0] a,
                                   input logic [WW-1:0] b);
        longint s = 0;
        for (int k = 0; k < LANES; k++) begin
            longint x = longint'($signed(a[k*IWIDTH +: IWIDTH]));
            longint y = longint'($signed(b[k*IWIDTH +: IWIDTH]));
            s += x * y;
        end
        return s;
    endfunction

    task automatic tick();
        logic                     expv;
        logic signed [OWIDTH-1:0] expr;
        @(posedge clk);
        #1;
        cyc++;
        expv = (q.size() > 0 && q[0].due == cyc);
        expr = expv ? q[0].val : last_res;
        checks++;
        assert (bus.ovalid === expv) else begin
            failures++;
            $error("FAIL ovalid cyc=%0d observed=%b expected=%b",
                   cyc, bus.ovalid, expv);
        end
        checks++;
        assert (bus.result === expr) else begin
            failures++;
            $error("FAIL result cyc=%0d observed=%0d expected=%0d",
                   cyc, bus.result, expr);
        end
        if (expv) begin
            last_res = expr;
            void'(q.pop_front());
        end
    endtask

    task automatic beat(input logic v, input logic [WW-1:0] vw,
                        input logic [WW-1:0] mw,
                        input logic f, input logic l);
        longint s;
        exp_t   e;
        bus.ivalid      = v;
        bus.vec_data    = vw;
        bus.mat_data    = mw;
        bus.accum_first = f;
        bus.accum_last  = l;
        tick();
        if (v) begin
            s = dot(vw, mw);
            acc_m = f ? s : acc_m + s;
`ifdef DOT_ACCUM_SAT_EN
            if (acc_m > 64'sd2147483647)       acc_m = 64'sd2147483647;
            else if (acc_m < -64'sd2147483648) acc_m = -64'sd2147483648;
`else
            acc_m = longint'(int'(acc_m));
`endif
            if (l) begin
                e.due = cyc + LAT;
                e.val = OWIDTH'(acc_m);
                q.push_back(e);
            end
        end
        bus.ivalid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            beat(1'b0, {$urandom, $urandom}, {$urandom, $urandom},
                 1'($urandom), 1'($urandom));
    endtask

    task automatic do_reset();
        q.delete();
        acc_m    = 0;
        last_res = '0;
        rst      = 1'b1;
        bus.ivalid = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        bus.ivalid      = 1'b0;
        bus.vec_data    = '0;
        bus.mat_data    = '0;
        bus.accum_first = 1'b0;
        bus.accum_last  = 1'b0;
        do_reset();
        do_reset();
        idle(2);

        // single-word row: 8 * 1 * 2
        beat(1, rep(8'd1), rep(8'd2), 1, 1);
        idle(8);

        // three consecutive words of 3 * -1
        beat(1, rep(8'd3), rep(8'hFF), 1, 0);
        beat(1, rep(8'd3), rep(8'hFF), 0, 0);
        beat(1, rep(8'd3), rep(8'hFF), 0, 1);
        idle(8);

        // same row with bubbles, then a single-word row right after
        beat(1, rep(8'd3), rep(8'hFF), 1, 0);
        idle(2);
        beat(1, rep(8'd3), rep(8'hFF), 0, 0);
        idle(2);
        beat(1, rep(8'd3), rep(8'hFF), 0, 1);
        beat(1, rep(8'd1), rep(8'd1), 1, 1);
        idle(8);

        // back-to-back single-word rows
        for (int k = 1; k <= 8; k++)
            beat(1, rep(IWIDTH'(k)), rep(8'd1), 1, 1);
        idle(8);

        // reset aborts a row in flight
        beat(1, rep(8'd7), rep(8'd7), 1, 0);
        beat(1, rep(8'd7), rep(8'd7), 0, 0);
        do_reset();
        beat(1, rep(8'd1), rep(8'd5), 1, 1);
        idle(8);

        // row without a first beat after reset starts from zero
        do_reset();
        beat(1, rep(8'd2), rep(8'd2), 0, 0);
        beat(1, rep(8'd1), rep(8'd3), 0, 1);
        idle(8);

        // random rows with random bubbles
        for (int r = 0; r < 200; r++) begin
            int len = int'($urandom_range(1, 5));
            for (int w = 0; w < len; w++) begin
                while ($urandom_range(0, 2) == 0) idle(1);
                beat(1, {$urandom, $urandom}, {$urandom, $urandom},
                     w == 0, w == len - 1);
            end
        end
        idle(8);

        // long row of max-magnitude products overflows 32 bits
        do_reset();
        for (int i = 0; i < 16385; i++)
            beat(1, rep(8'h80), rep(8'h80), i == 0, i == 16384);
        idle(10);

        checks++;
        assert (q.size() === 0) else begin
            failures++;
            $error("FAIL drain observed=%0d expected=0 pending", q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dot_accum.md
Name: dot_accum

Overview:
- Compute lane of the MVM engine, directly downstream of the control FSM and the vector/matrix BRAMs.
- Each valid beat carries one vector word and one matrix word of LANES signed elements, plus accum_first/accum_last flags aligned to the BRAM read data.
- Computes the word dot product through a fixed-latency pipelined multiply/adder tree and accumulates across the words of a row.
- Emits one signed row result with a single-cycle valid pulse per row.

Parameters:
- LANES, 8: elements per word; power of two, >= 2.
- IWIDTH, 8: signed element width.
- OWIDTH, 32: signed accumulator/result width; must be >= 2*IWIDTH + log2(LANES).

Ports:
- clk  input  1  clock
- rst  input  1  reset; synchronous, active-high
- ivalid  input  1  beat valid; data and flags below sampled only when high
- vec_data  input  LANES*IWIDTH  vector word; element k at bits [k*IWIDTH +: IWIDTH]
- mat_data  input  LANES*IWIDTH  matrix word; same packing
- accum_first  input  1  beat is first word of a row
- accum_last  input  1  beat is last word of a row
- result  output  OWIDTH  signed row dot product
- ovalid  output  1  single-cycle pulse; result valid

Behaviour:
- Reset: all pipeline valid bits, the accumulator, result and ovalid clear to 0 on the clock edge where rst=1. Data registers need not be reset. rst mid-row discards all in-flight beats, and no ovalid is produced for them.
- Pipeline, one stage per cycle, no stalls, no backpressure:
  - S0 registers the inputs.
  - S1 computes LANES signed products of width 2*IWIDTH.
  - S2..S(1+log2 LANES) form a binary adder tree; each level sign-extends by 1 bit.
  - Final stage is the accumulate.
- Latency: a beat sampled at edge N with accum_last=1 produces ovalid=1 after edge N + 3 + log2(LANES). This is 6 cycles for LANES=8.
- valid, first and last flags travel with their data through every stage. Beats with ivalid=0 are bubbles: they do not modify the accumulator and produce no output.
- Accumulate stage, valid beat with tree sum s:
  - first=1: acc <= sext(s).
  - first=0: acc <= acc + sext(s), modulo 2^OWIDTH (two's complement wrap).
  - first=1 and last=1 together: single-word row, result = sext(s).
  - last=1: result <= the new acc value, ovalid <= 1 for exactly one cycle.
  - Otherwise ovalid <= 0; result holds its last value between pulses.
- Bubbles may appear anywhere inside a row; the result is unaffected.
- Back-to-back rows: a first beat immediately following a last beat starts a fresh sum with no carry-over. Consecutive single-word rows give ovalid high on consecutive cycles.
- A beat with first=0 arriving after reset, before any first beat, accumulates onto acc=0.
- Throughput: one beat per cycle sustained.

Optional Feature:
- Macro: DOT_ACCUM_SAT_EN.
- Defined: non-first accumulation saturates to the signed OWIDTH range.
  - Positive overflow clamps to 2^(OWIDTH-1)-1.
  - Negative overflow clamps to -2^(OWIDTH-1).
  - Saturation is sticky only in value: later beats continue adding from the clamped value.
  - First beats cannot overflow, given the OWIDTH constraint.
- Undefined: plain modulo-2^OWIDTH wrap. No extra logic or ports in either case.

Test Plan (defaults LANES=8, IWIDTH=8, OWIDTH=32):
1. Single beat, first=last=1, all vec elements 1, all mat elements 2 -> ovalid pulse exactly 6 cycles after the sampling edge, result=16.
2. Three-word row, vec elements 3, mat elements -1, beats on consecutive cycles -> one ovalid pulse 6 cycles after the last beat, result=-72, no pulses earlier.
3. Same row as test 2 with 2 idle cycles between each beat, immediately followed by a single-word row of all 1s × all 1s -> pulses result=-72, then result=8; no cross-row contamination.
4. Eight consecutive single-word rows with vec=k, mat=1 for k=1..8 -> ovalid high 8 consecutive cycles, results 8, 16, ..., 64.
5. Two beats of a row, then rst for 1 cycle, then a fresh single-word row vec=1, mat=5 -> no pulse for the aborted row, next pulse result=40.
6. 16385-beat row, all elements -128 × -128 (131072 per word) -> with DOT_ACCUM_SAT_EN, result=2147483647; without it, result=-2147352576.
